// File: rtl/ctrl_pkg.sv
// Shared encodings, the control bundle type and the stage FSM states for the
// RV32I(+M) decode/control stage.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_TYPE_DEFAULT = 3'd0;
    localparam logic [2:0] IMM_TYPE_SHAMT   = 3'd1;
    localparam logic [2:0] IMM_TYPE_I       = 3'd2;
    localparam logic [2:0] IMM_TYPE_S       = 3'd3;
    localparam logic [2:0] IMM_TYPE_B       = 3'd4;
    localparam logic [2:0] IMM_TYPE_U       = 3'd5;
    localparam logic [2:0] IMM_TYPE_J       = 3'd6;

    localparam logic [1:0] RSRC_ALU = 2'b00;
    localparam logic [1:0] RSRC_MEM = 2'b01;
    localparam logic [1:0] RSRC_PC  = 2'b11;
    localparam logic [1:0] RSRC_DC  = 2'b10;

    localparam logic [1:0] ASRC_RS1  = 2'b00;
    localparam logic [1:0] ASRC_ZERO = 2'b01;
    localparam logic [1:0] ASRC_PC   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic       inv;
        logic       aluSrcB;
        logic [4:0] aluCntrl;
        logic [2:0] immCntrl;
        logic [1:0] aluSrcA;
        logic [1:0] regSrc;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c          = '0;
        c.aluSrcA  = ASRC_RS1;
        c.regSrc   = RSRC_DC;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I(+M) decoder: instruction word to control bundle,
// M-op flag and illegal-instruction flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl_o,
    output logic        is_m_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       m_allowed;
    ctrl_t      c;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign m_allowed     = (ENABLE_M != 0);
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        c         = ctrl_reset();
        is_m_o    = 1'b0;
        illegal_o = 1'b0;
        unique case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT ||
                    (funct7 == F7_MEXT && m_allowed)) begin
                    is_m_o     = (funct7 == F7_MEXT);
                    c.regWrite = 1'b1;
                    c.aluCntrl = {is_m_o, funct7[5], funct3};
                    c.regSrc   = RSRC_ALU;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_IMM: begin
                c.regWrite = 1'b1;
                c.regSrc   = RSRC_ALU;
                // Only SRLI/SRAI carry an ALU variant bit in funct7; other I-ops have immediate bits there.
                c.aluCntrl = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                c.immCntrl = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_TYPE_SHAMT : IMM_TYPE_I;
            end
            OPC_LOAD: begin
                c.regWrite = 1'b1;
                c.immCntrl = IMM_TYPE_I;
                c.regSrc   = RSRC_MEM;
            end
            OPC_STORE: begin
                c.memWrite = 1'b1;
                c.immCntrl = IMM_TYPE_S;
            end
            OPC_BRANCH: begin
                c.branch   = 1'b1;
                c.inv      = funct3[0];
                c.aluCntrl = {3'b010, funct3[2:1]};
                c.immCntrl = IMM_TYPE_B;
            end
            OPC_LUI: begin
                c.regWrite = 1'b1;
                c.immCntrl = IMM_TYPE_U;
                c.aluSrcA  = ASRC_ZERO;
                c.regSrc   = RSRC_ALU;
            end
            OPC_AUIPC: begin
                c.regWrite = 1'b1;
                c.immCntrl = IMM_TYPE_U;
                c.aluSrcA  = ASRC_PC;
                c.regSrc   = RSRC_ALU;
            end
            OPC_JAL: begin
                c.regWrite = 1'b1;
                c.jump     = 1'b1;
                c.immCntrl = IMM_TYPE_J;
                c.aluSrcA  = ASRC_PC;
                c.regSrc   = RSRC_PC;
            end
            OPC_JALR: begin
                c.regWrite = 1'b1;
                c.jump     = 1'b1;
                c.immCntrl = IMM_TYPE_I;
                c.regSrc   = RSRC_PC;
            end
            default: illegal_o = 1'b1;
        endcase

        // Quadrant bits 00/01/10 are compressed encodings, not supported here.
        if (instr[1:0] != 2'b11) begin
            illegal_o = 1'b1;
            is_m_o    = 1'b0;
        end
        if (illegal_o) begin
            c = ctrl_reset();
        end
        c.aluSrcB = |c.immCntrl;
        ctrl_o    = c;
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode/control stage: decoder plus a valid/ready holding register
// that stalls fetch for the fixed occupancy of multiply/divide operations.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regWrite,
    output logic        memWrite,
    output logic        branch,
    output logic        jump,
    output logic        inv,
    output logic        aluSrcB,
    output logic [4:0]  aluCntrl,
    output logic [2:0]  immCntrl,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  regSrc,
    output logic        illegal,
    output logic [4:0]  mCycles
);

    localparam logic [4:0] MUL_WAIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_WAIT = 5'(DIV_CYCLES - 1);

    ctrl_t      dec_ctrl;
    logic       dec_is_m;
    logic       dec_illegal;

    state_e     state_q;
    ctrl_t      ctrl_q;
    logic       illegal_q;
    logic [4:0] mcyc_q;

    logic       accept;
    logic [4:0] wait_d;
    state_e     load_state_d;

    ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr     (instr),
        .ctrl_o    (dec_ctrl),
        .is_m_o    (dec_is_m),
        .illegal_o (dec_illegal)
    );

    assign in_ready  = !flush && ((state_q == ST_EMPTY) || (state_q == ST_FULL && out_ready));
    assign accept    = in_ready && in_valid;
    assign out_valid = (state_q == ST_FULL);

    // Divide-class M ops have funct3[2]=1; a single-cycle occupancy needs no WAIT visit.
    assign wait_d       = dec_is_m ? (instr[14] ? DIV_WAIT : MUL_WAIT) : 5'd0;
    assign load_state_d = (wait_d != 5'd0) ? ST_WAIT : ST_FULL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            ctrl_q    <= ctrl_reset();
            illegal_q <= 1'b0;
            mcyc_q    <= 5'd0;
        end else if (flush) begin
            state_q   <= ST_EMPTY;
            ctrl_q    <= ctrl_reset();
            illegal_q <= 1'b0;
            mcyc_q    <= 5'd0;
        end else if (accept) begin
            state_q   <= load_state_d;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            mcyc_q    <= wait_d;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (mcyc_q <= 5'd1) begin
                        state_q <= ST_FULL;
                        mcyc_q  <= 5'd0;
                    end else begin
                        mcyc_q  <= mcyc_q - 5'd1;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_EMPTY: state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    assign regWrite = ctrl_q.regWrite;
    assign memWrite = ctrl_q.memWrite;
    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign inv      = ctrl_q.inv;
    assign aluSrcB  = ctrl_q.aluSrcB;
    assign aluCntrl = ctrl_q.aluCntrl;
    assign immCntrl = ctrl_q.immCntrl;
    assign aluSrcA  = ctrl_q.aluSrcA;
    assign regSrc   = ctrl_q.regSrc;
    assign illegal  = illegal_q;
    assign mCycles  = mcyc_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode fields, M-op latency, stall,
// flush, illegal handling (with and without M) and asynchronous reset.
module tb_id_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready, out_valid, regWrite, memWrite, branch, jump, inv, aluSrcB, illegal;
    logic [4:0]  aluCntrl, mCycles;
    logic [2:0]  immCntrl;
    logic [1:0]  aluSrcA, regSrc;

    logic        n_in_ready, n_out_valid, n_regWrite, n_memWrite, n_branch, n_jump, n_inv;
    logic        n_aluSrcB, n_illegal;
    logic [4:0]  n_aluCntrl, n_mCycles;
    logic [2:0]  n_immCntrl;
    logic [1:0]  n_aluSrcA, n_regSrc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_DIV   = 32'h0231C0B3;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_AUIPC = 32'h00001097;

    id_ctrl_stage u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .regWrite(regWrite), .memWrite(memWrite), .branch(branch), .jump(jump), .inv(inv),
        .aluSrcB(aluSrcB), .aluCntrl(aluCntrl), .immCntrl(immCntrl), .aluSrcA(aluSrcA),
        .regSrc(regSrc), .illegal(illegal), .mCycles(mCycles)
    );

    id_ctrl_stage #(.ENABLE_M(0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .instr(instr), .out_valid(n_out_valid), .out_ready(out_ready),
        .regWrite(n_regWrite), .memWrite(n_memWrite), .branch(n_branch), .jump(n_jump),
        .inv(n_inv), .aluSrcB(n_aluSrcB), .aluCntrl(n_aluCntrl), .immCntrl(n_immCntrl),
        .aluSrcA(n_aluSrcA), .regSrc(n_regSrc), .illegal(n_illegal), .mCycles(n_mCycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_regSrc",    regSrc,    2);
        chk("rst_aluSrcA",   aluSrcA,   0);
        chk("rst_mCycles",   mCycles,   0);
        chk("rst_in_ready",  in_ready,  1);
        rst_n = 1'b1;
        #1;

        // back-to-back add then lw
        in_valid = 1'b1;
        instr    = I_ADD;
        #1 chk("b2b_in_ready0", in_ready, 1);
        tick();
        chk("add_out_valid", out_valid, 1);
        chk("add_aluCntrl",  aluCntrl,  0);
        chk("add_regSrc",    regSrc,    0);
        chk("add_regWrite",  regWrite,  1);
        chk("add_illegal",   illegal,   0);
        instr = I_LW;
        #1 chk("b2b_in_ready1", in_ready, 1);
        tick();
        chk("lw_out_valid", out_valid, 1);
        chk("lw_regSrc",    regSrc,    1);
        chk("lw_immCntrl",  immCntrl,  2);
        chk("lw_aluSrcB",   aluSrcB,   1);

        // stall: offered add must not replace the held lw
        out_ready = 1'b0;
        instr     = I_ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_regSrc",    regSrc,    1);
            chk("stall_immCntrl",  immCntrl,  2);
            chk("stall_in_ready",  in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("drain_out_valid", out_valid, 0);

        // mul: one WAIT cycle
        in_valid = 1'b1;
        instr    = I_MUL;
        #1 chk("mul_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mul_wait_valid",   out_valid, 0);
        chk("mul_wait_mcyc",    mCycles,   1);
        chk("mul_wait_ready",   in_ready,  0);
        chk("nom_mul_illegal",  n_illegal, 1);
        chk("nom_mul_regWrite", n_regWrite, 0);
        chk("nom_mul_valid",    n_out_valid, 1);
        tick();
        chk("mul_out_valid", out_valid, 1);
        chk("mul_aluCntrl",  aluCntrl,  5'b10000);
        chk("mul_mcyc",      mCycles,   0);

        // div: 15 WAIT cycles, fetch stalled throughout
        in_valid = 1'b1;
        instr    = I_DIV;
        #1 chk("div_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 15; k++) begin
            chk("div_wait_valid", out_valid, 0);
            chk("div_wait_ready", in_ready,  0);
            chk("div_wait_mcyc",  mCycles,   32'(15 - k));
            tick();
        end
        chk("div_out_valid", out_valid, 1);
        chk("div_aluCntrl",  aluCntrl,  5'b10100);

        // flush during WAIT drops the offered instruction
        in_valid = 1'b1;
        instr    = I_DIV;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("flush_pre_mcyc", mCycles, 7);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = I_ADD;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_mcyc",      mCycles,   0);
        chk("flush_regWrite",  regWrite,  0);
        chk("flush_regSrc",    regSrc,    2);
        tick();
        chk("flush_dropped", out_valid, 0);

        // bne
        in_valid = 1'b1;
        instr    = I_BNE;
        tick();
        chk("bne_branch",   branch,   1);
        chk("bne_inv",      inv,      1);
        chk("bne_aluCntrl", aluCntrl, 5'b01000);
        chk("bne_immCntrl", immCntrl, 4);
        chk("bne_aluSrcB",  aluSrcB,  1);
        chk("bne_regWrite", regWrite, 0);

        // srai, jal
        instr = I_SRAI;
        tick();
        chk("srai_aluCntrl", aluCntrl, 5'b01101);
        chk("srai_immCntrl", immCntrl, 1);
        instr = I_JAL;
        tick();
        chk("jal_jump",     jump,     1);
        chk("jal_regSrc",   regSrc,   3);
        chk("jal_immCntrl", immCntrl, 6);
        chk("jal_aluSrcA",  aluSrcA,  3);

        // all-zero word is illegal
        instr = 32'h0;
        tick();
        chk("ill_illegal",   illegal,  1);
        chk("ill_out_valid", out_valid, 1);
        chk("ill_enables",   {regWrite, memWrite, branch, jump}, 0);

        // async reset while FULL with auipc
        instr = I_AUIPC;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("auipc_aluSrcA",  aluSrcA,  3);
        chk("auipc_immCntrl", immCntrl, 5);
        chk("auipc_valid",    out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_regWrite",  regWrite,  0);
        chk("arst_regSrc",    regSrc,    2);
        chk("arst_aluSrcA",   aluSrcA,   0);
        #5 rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
